product_accumulator: RTL
========================

# product_accumulator

Packet accumulator that sits directly downstream of the pipelined array multiplier. It receives the multiplier's full-width products as a valid/ready stream and sums each packet of products, where a packet is delimited by `in_last`. Each completed sum is presented on a registered output handshake, together with the packet's beat count and an overflow flag. It turns the multiplier into a dot-product / MAC datapath.

## Interface
Parameters:
- `WIDTH`, 8: multiplier operand width; products are `2*WIDTH` bits.
- `ACC_WIDTH`, 24: accumulator and result width; must be ≥ `2*WIDTH`.
- `COUNT_WIDTH`, 8: beat-counter width.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: product beat valid.
- `in_ready`  out  1: block accepts a beat this cycle.
- `in_data`  in  `2*WIDTH`: unsigned product from the multiplier.
- `in_last`  in  1: this beat ends the packet.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_data`  out  `ACC_WIDTH`: packet sum.
- `out_count`  out  `COUNT_WIDTH`: number of beats in the packet.
- `out_ovf`  out  1: the sum exceeded `ACC_WIDTH` bits during the packet.

## Operation
- Beat acceptance: a beat is accepted when `in_valid && in_ready`.
- `in_ready = !rst && !(out_valid && !out_ready)`.
  - The block stalls only while a result is held and not yet taken.
  - `in_ready` has no combinational path from `in_valid` or `in_last`.
- Internal state: accumulator `acc` (`ACC_WIDTH`), counter `cnt` (`COUNT_WIDTH`), sticky flag `ovf`.
- Accepting a non-last beat:
  - `acc <= acc + zext(in_data)`.
  - `cnt <= cnt + 1`, saturating at all-ones.
  - `ovf <= ovf | carry_out`.
- Accepting a last beat:
  - The output registers load the updated values: `acc + zext(in_data)`, `cnt + 1` (saturating), and `ovf | carry`.
  - `out_valid <= 1`.
  - `acc`, `cnt` and `ovf` clear to 0 in the same edge, so the next beat starts a new packet.
- Output handshake:
  - A result transfers when `out_valid && out_ready`.
  - If a last beat is not accepted in that same cycle, `out_valid <= 0`.
  - If a last beat is accepted in that same cycle, the new result loads and `out_valid` stays 1.
- Output stability: `out_data`, `out_count` and `out_ovf` hold their values while `out_valid && !out_ready`.
- Two-state FSM:
  - EMPTY (`out_valid=0`) goes to FULL on acceptance of a last beat.
  - FULL goes to EMPTY on a transfer with no last beat accepted that cycle.
  - FULL stays FULL on a transfer plus acceptance of a last beat.
- Single-beat packet (`in_last` on the first beat): result = `in_data`, count = 1.
- Arithmetic: unsigned only. Overflow behaviour is set by the Configuration section.

## Timing
- Reset values, in the cycle after `rst` is sampled high:
  - `out_valid=0`, `out_data=0`, `out_count=0`, `out_ovf=0`.
  - `acc=0`, `cnt=0`, `ovf=0`.
  - `in_ready=0` while `rst` is high; `in_ready=1` in the first cycle after `rst` falls.
- Reset mid-packet: discards the partial sum.
- Reset while FULL: drops the held result.
- Latency: last beat accepted at edge N → `out_valid=1` and result visible immediately after edge N.
- Throughput: one beat per cycle, including back-to-back packets, provided `out_ready` is held high.
- Stall: with `out_valid=1` and `out_ready=0`, `in_ready=0` and no state changes. The upstream multiplier pipeline must hold its product.
- Count saturation: `out_count` saturates at `2^COUNT_WIDTH-1`. `out_data` and `out_ovf` remain correct beyond that count.

## Configuration
- Macro: `PRODUCT_ACC_SAT_EN`.
- Defined:
  - On carry-out, `acc` saturates to all-ones and stays there for the rest of the packet.
  - `ovf` is set.
- Undefined:
  - `acc` wraps modulo `2^ACC_WIDTH`.
  - `ovf` is still set sticky on any carry-out within the packet.
- The handshake and count behaviour are identical in both builds.

## Test plan
- Basic sum: `WIDTH=8`, `ACC_WIDTH=24`, `out_ready=1`; beats 6, 35, 100 (last) → one cycle after the last beat, `out_data=141`, `out_count=3`, `out_ovf=0`, `out_valid` high for one cycle.
- Single beat plus back-to-back: packet {65025, last} immediately followed by {1, last} → consecutive results 65025/1 then 1/1; `in_ready` stays 1 throughout.
- Backpressure: `out_ready=0` after the first result completes → `in_ready=0` and outputs stable for 5 cycles. Raise `out_ready` together with a pending last beat → transfer and new result load on the same edge, `out_valid` stays 1.
- Overflow (`ACC_WIDTH=16`): beats 65025, 65025 (last) → without the macro, `out_data=64514`, `out_ovf=1`; with `PRODUCT_ACC_SAT_EN`, `out_data=65535`, `out_ovf=1`.
- Count saturation: `COUNT_WIDTH=4`, 20 beats of value 1 → `out_count=15`, `out_data=20`.
- Reset mid-packet: 3 beats of 10, `rst` for 1 cycle, then {7, last} → `out_data=7`, `out_count=1`; all outputs are 0 in the cycle after reset.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator: sums packets of multiplier products into a registered result with beat count and overflow flag.
// Define PRODUCT_ACC_SAT_EN to saturate the running sum on overflow instead of wrapping.
module product_accumulator #(
    parameter int WIDTH = 8,
    parameter int ACC_WIDTH = 24,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*WIDTH-1:0]     in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_data,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_ovf
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_next;
    logic [ACC_WIDTH-1:0] acc, acc_next, sum;
    logic [COUNT_WIDTH-1:0] cnt, cnt_next;
    logic ovf, ovf_next, carry, accept, xfer;
    assign {carry, sum} = {1'b0, acc} + {{(ACC_WIDTH-2*WIDTH+1){1'b0}}, in_data};
`ifdef PRODUCT_ACC_SAT_EN
    // once saturated, any further nonzero product carries again, so the sum stays pinned
    assign acc_next = carry ? '1 : sum;
`else
    assign acc_next = sum;
`endif
    assign cnt_next = &cnt ? cnt : cnt + 1'b1;
    assign ovf_next = ovf | carry;
    assign in_ready = !rst && !(out_valid && !out_ready);
    assign accept = in_valid && in_ready;
    assign xfer = out_valid && out_ready;
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else state <= state_next;
    end
    always_comb begin
        state_next = state;
        if (accept && in_last) state_next = FULL;
        else if (xfer) state_next = EMPTY;
    end
    always_comb begin
        out_valid = state == FULL;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            out_data <= '0;
            out_count <= '0;
            out_ovf <= 1'b0;
        end else if (accept) begin
            acc <= in_last ? '0 : acc_next;
            cnt <= in_last ? '0 : cnt_next;
            ovf <= in_last ? 1'b0 : ovf_next;
            if (in_last) begin
                out_data <= acc_next;
                out_count <= cnt_next;
                out_ovf <= ovf_next;
            end
        end
    end
endmodule
